// File: rtl/cfu_pkg.sv
// Shared CFU-L2 definitions: response status codes and the in-order tag entry
// used by the request router.
package cfu_pkg;

  localparam int CFU_STATUS_W  = 3;
  localparam int CFU_TAG_IDX_W = 4;  // enough for up to 16 subordinates

  localparam logic [CFU_STATUS_W-1:0] CFU_OK        = 3'd0;
  localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_CFU = 3'd1;

  typedef struct packed {
    logic                     bad;
    logic [CFU_TAG_IDX_W-1:0] idx;
  } cfu_tag_t;

  localparam int CFU_TAG_W = $bits(cfu_tag_t);

endpackage

// File: rtl/cfu_tag_fifo.sv
// Synchronous FIFO holding one tag per outstanding request, oldest at head.
// All state updates are gated by clk_en; reset clears pointers and count.
module cfu_tag_fifo
  import cfu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CFU_TAG_W,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = clk_en && push && !full;
  assign do_pop  = clk_en && pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; count and pointers alone decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/switch_cfu.sv
// CFU-L2 router: steers each request to the subordinate chosen by req_cfu and
// returns responses strictly in request order using a tag FIFO.
module switch_cfu
  import cfu_pkg::*;
#(
  parameter int CFU_N_CFUS     = 2,
  parameter int CFU_FUNC_ID_W  = 10,
  parameter int CFU_DATA_W     = 32,
  parameter int CFU_STATE_ID_W = 0,
  parameter int CFU_INSN_W     = 0,
  parameter int MAX_OUT        = 4,
  localparam int CFU_ID_W = ($clog2(CFU_N_CFUS + 1) > 1) ? $clog2(CFU_N_CFUS + 1) : 1,
  localparam int STATE_W  = (CFU_STATE_ID_W > 0) ? CFU_STATE_ID_W : 1,
  localparam int INSN_W   = (CFU_INSN_W > 0) ? CFU_INSN_W : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clk_en,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [CFU_ID_W-1:0]                  req_cfu,
  input  logic [STATE_W-1:0]                   req_state,
  input  logic [CFU_FUNC_ID_W-1:0]             req_func,
  input  logic [INSN_W-1:0]                    req_insn,
  input  logic [CFU_DATA_W-1:0]                req_data0,
  input  logic [CFU_DATA_W-1:0]                req_data1,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [CFU_STATUS_W-1:0]              resp_status,
  output logic [CFU_DATA_W-1:0]                resp_data,
  output logic [CFU_N_CFUS-1:0]                t_req_valid,
  input  logic [CFU_N_CFUS-1:0]                t_req_ready,
  output logic [STATE_W-1:0]                   t_req_state,
  output logic [CFU_FUNC_ID_W-1:0]             t_req_func,
  output logic [INSN_W-1:0]                    t_req_insn,
  output logic [CFU_DATA_W-1:0]                t_req_data0,
  output logic [CFU_DATA_W-1:0]                t_req_data1,
  input  logic [CFU_N_CFUS-1:0]                t_resp_valid,
  output logic [CFU_N_CFUS-1:0]                t_resp_ready,
  input  logic [CFU_N_CFUS*CFU_STATUS_W-1:0]   t_resp_status,
  input  logic [CFU_N_CFUS*CFU_DATA_W-1:0]     t_resp_data
);

  localparam int SEL_W = CFU_TAG_IDX_W + 1;

  logic [SEL_W-1:0] sel;
  logic             in_range;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cfu_tag_t         push_tag;
  cfu_tag_t         head_tag;
  logic [CFU_TAG_W-1:0] head_bits;

  assign sel      = SEL_W'(req_cfu);
  assign in_range = (sel < SEL_W'(CFU_N_CFUS));

  assign push_tag.bad = !in_range;
  assign push_tag.idx = sel[CFU_TAG_IDX_W-1:0];
  assign head_tag     = cfu_tag_t'(head_bits);

  assign push = req_valid && req_ready;
  assign pop  = resp_valid && resp_ready;

  assign t_req_state = req_state;
  assign t_req_func  = req_func;
  assign t_req_insn  = req_insn;
  assign t_req_data0 = req_data0;
  assign t_req_data1 = req_data1;

  // Request path. Full blocks acceptance regardless of a same-cycle pop, which
  // keeps resp_ready out of the req_ready cone.
  always_comb begin
    req_ready   = 1'b0;
    t_req_valid = '0;
    if (clk_en && !full) begin
      req_ready = !in_range;
      for (int i = 0; i < CFU_N_CFUS; i++) begin
        if (in_range && sel == SEL_W'(i)) begin
          t_req_valid[i] = req_valid;
          req_ready      = t_req_ready[i];
        end
      end
    end
  end

  // Response path: only the subordinate named by the head tag is listened to.
  always_comb begin
    resp_valid   = 1'b0;
    resp_status  = CFU_OK;
    resp_data    = '0;
    t_resp_ready = '0;
    if (clk_en && !empty) begin
      if (head_tag.bad) begin
        resp_valid  = 1'b1;
        resp_status = CFU_ERROR_CFU;
      end else begin
        for (int i = 0; i < CFU_N_CFUS; i++) begin
          if (head_tag.idx == CFU_TAG_IDX_W'(i)) begin
            resp_valid      = t_resp_valid[i];
            resp_status     = t_resp_status[i*CFU_STATUS_W +: CFU_STATUS_W];
            resp_data       = t_resp_data[i*CFU_DATA_W +: CFU_DATA_W];
            t_resp_ready[i] = resp_ready;
          end
        end
      end
    end
  end

  cfu_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (CFU_TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .push      (push),
    .push_data (push_tag),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head_bits)
  );

endmodule

// File: tb/tb_switch_cfu.sv
// Directed bench for switch_cfu with two subordinates and four tag slots:
// a combinational vector table plus hand-written multi-cycle sequences.
module tb_switch_cfu;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cfu;
  logic [0:0]  req_state;
  logic [9:0]  req_func;
  logic [0:0]  req_insn;
  logic [31:0] req_data0;
  logic [31:0] req_data1;
  logic        resp_valid;
  logic        resp_ready;
  logic [2:0]  resp_status;
  logic [31:0] resp_data;
  logic [1:0]  t_req_valid;
  logic [1:0]  t_req_ready;
  logic [0:0]  t_req_state;
  logic [9:0]  t_req_func;
  logic [0:0]  t_req_insn;
  logic [31:0] t_req_data0;
  logic [31:0] t_req_data1;
  logic [1:0]  t_resp_valid;
  logic [1:0]  t_resp_ready;
  logic [5:0]  t_resp_status;
  logic [63:0] t_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_cfu dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cfu       (req_cfu),
    .req_state     (req_state),
    .req_func      (req_func),
    .req_insn      (req_insn),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_status   (resp_status),
    .resp_data     (resp_data),
    .t_req_valid   (t_req_valid),
    .t_req_ready   (t_req_ready),
    .t_req_state   (t_req_state),
    .t_req_func    (t_req_func),
    .t_req_insn    (t_req_insn),
    .t_req_data0   (t_req_data0),
    .t_req_data1   (t_req_data1),
    .t_resp_valid  (t_resp_valid),
    .t_resp_ready  (t_resp_ready),
    .t_resp_status (t_resp_status),
    .t_resp_data   (t_resp_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    req_valid    = 1'b0;
    req_cfu      = 2'd0;
    t_req_ready  = 2'b11;
    t_resp_valid = 2'b00;
    resp_ready   = 1'b0;
    t_resp_status = '0;
    t_resp_data   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       v;
    logic [1:0] cfu;
    logic [1:0] tr;
    logic       exp_ready;
    logic [1:0] exp_tv;
  } vec_t;

  vec_t vecs[9];

  int accepted;
  logic last_ready;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    clk_en    = 1'b1;
    req_state = 1'b0;
    req_insn  = 1'b0;
    req_func  = 10'h2a5;
    req_data0 = 32'h1234_5678;
    req_data1 = 32'h9abc_def0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, with subordinates shouting so a stale tag would show.
    t_resp_valid = 2'b11;
    resp_ready   = 1'b1;
    #1;
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset t_req_valid", 64'(t_req_valid), 64'd0);
    check("reset t_resp_ready", 64'(t_resp_ready), 64'd0);
    check("payload func", 64'(t_req_func), 64'h2a5);
    check("payload data0", 64'(t_req_data0), 64'h1234_5678);
    check("payload data1", 64'(t_req_data1), 64'h9abc_def0);

    // Request-path table on an empty FIFO; req_valid drops before the edge.
    vecs[0] = '{1'b1, 1'b1, 2'd0, 2'b11, 1'b1, 2'b01};
    vecs[1] = '{1'b1, 1'b1, 2'd1, 2'b01, 1'b0, 2'b10};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 2'b10, 1'b1, 2'b10};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 2'b11, 1'b1, 2'b00};
    vecs[4] = '{1'b1, 1'b1, 2'd2, 2'b11, 1'b1, 2'b00};
    vecs[5] = '{1'b1, 1'b1, 2'd3, 2'b00, 1'b1, 2'b00};
    vecs[6] = '{1'b0, 1'b1, 2'd0, 2'b11, 1'b0, 2'b00};
    vecs[7] = '{1'b0, 1'b1, 2'd2, 2'b11, 1'b0, 2'b00};
    vecs[8] = '{1'b1, 1'b1, 2'd0, 2'b10, 1'b0, 2'b01};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      clk_en      = vecs[i].en;
      req_valid   = vecs[i].v;
      req_cfu     = vecs[i].cfu;
      t_req_ready = vecs[i].tr;
      t_resp_valid = 2'b11;
      resp_ready   = 1'b1;
      #1;
      check($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      check($sformatf("vec%0d t_req_valid", i), 64'(t_req_valid), 64'(vecs[i].exp_tv));
      check($sformatf("vec%0d resp_valid", i), 64'(resp_valid), 64'd0);
      check($sformatf("vec%0d t_resp_ready", i), 64'(t_resp_ready), 64'd0);
      idle();
      clk_en = 1'b1;
    end

    // Single request to subordinate 0, answered one cycle later.
    @(negedge clk);
    req_valid = 1'b1; req_cfu = 2'd0; resp_ready = 1'b1;
    #1;
    check("A req_ready", 64'(req_ready), 64'd1);
    check("A t_req_valid", 64'(t_req_valid), 64'b01);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("A wait resp_valid", 64'(resp_valid), 64'd0);
    check("A wait t_resp_ready", 64'(t_resp_ready), 64'b01);
    @(negedge clk);
    t_resp_valid = 2'b01; t_resp_data[31:0] = 32'h11;
    #1;
    check("A resp_valid", 64'(resp_valid), 64'd1);
    check("A resp_data", 64'(resp_data), 64'h11);
    check("A resp_status", 64'(resp_status), 64'd0);
    check("A t_resp_ready", 64'(t_resp_ready), 64'b01);
    @(negedge clk);
    t_resp_valid = 2'b00;
    #1;
    check("A drained resp_valid", 64'(resp_valid), 64'd0);
    check("A drained t_resp_ready", 64'(t_resp_ready), 64'b00);

    // Out-of-order completion: cfu1 then cfu0, subordinate 0 answers first.
    @(negedge clk);
    idle(); req_valid = 1'b1; req_cfu = 2'd1;
    @(negedge clk);
    req_cfu = 2'd0;
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    t_resp_valid = 2'b01; t_resp_data[31:0] = 32'hA; t_resp_status[2:0] = 3'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("B hold%0d resp_valid", c), 64'(resp_valid), 64'd0);
      check($sformatf("B hold%0d t_resp_ready", c), 64'(t_resp_ready), 64'b10);
      @(negedge clk);
    end
    t_resp_valid = 2'b11; t_resp_data[63:32] = 32'hB; t_resp_status[5:3] = 3'd2;
    #1;
    check("B first data", 64'(resp_data), 64'hB);
    check("B first status", 64'(resp_status), 64'd2);
    check("B first t_resp_ready", 64'(t_resp_ready), 64'b10);
    @(negedge clk);
    t_resp_valid = 2'b01;
    #1;
    check("B second valid", 64'(resp_valid), 64'd1);
    check("B second data", 64'(resp_data), 64'hA);
    check("B second status", 64'(resp_status), 64'd0);
    check("B second t_resp_ready", 64'(t_resp_ready), 64'b01);
    @(negedge clk);
    t_resp_valid = 2'b00;
    #1;
    check("B drained resp_valid", 64'(resp_valid), 64'd0);

    // Out-of-range selector gets a local error response on the next cycle.
    @(negedge clk);
    idle(); req_valid = 1'b1; req_cfu = 2'd2;
    #1;
    check("C t_req_valid", 64'(t_req_valid), 64'b00);
    check("C req_ready", 64'(req_ready), 64'd1);
    check("C same-cycle resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("C resp_valid", 64'(resp_valid), 64'd1);
    check("C resp_status", 64'(resp_status), 64'd1);
    check("C resp_data", 64'(resp_data), 64'd0);
    check("C t_resp_ready", 64'(t_resp_ready), 64'b00);
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("C drained resp_valid", 64'(resp_valid), 64'd0);

    // Back-to-back push and pop in the same cycle.
    @(negedge clk);
    idle(); req_valid = 1'b1; req_cfu = 2'd0;
    @(negedge clk);
    req_cfu = 2'd1; resp_ready = 1'b1;
    t_resp_valid = 2'b01; t_resp_data[31:0] = 32'h21;
    #1;
    check("G resp_valid", 64'(resp_valid), 64'd1);
    check("G resp_data", 64'(resp_data), 64'h21);
    check("G req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    t_resp_valid = 2'b10; t_resp_data[63:32] = 32'h22;
    #1;
    check("G next resp_valid", 64'(resp_valid), 64'd1);
    check("G next resp_data", 64'(resp_data), 64'h22);
    @(negedge clk);
    t_resp_valid = 2'b00;
    #1;
    check("G drained resp_valid", 64'(resp_valid), 64'd0);

    // Fill: five offers with silent subordinates, exactly four accepted.
    @(negedge clk);
    idle();
    accepted   = 0;
    last_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      req_valid = 1'b1; req_cfu = 2'(k % 2);
      #1;
      if (req_ready) accepted++;
      last_ready = req_ready;
    end
    check("D accepted", 64'(accepted), 64'd4);
    check("D fifth req_ready", 64'(last_ready), 64'd0);
    @(negedge clk);
    req_cfu = 2'd0; t_resp_valid = 2'b01; resp_ready = 1'b1;
    #1;
    check("D pop resp_valid", 64'(resp_valid), 64'd1);
    check("D full during pop req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = 1'b0; t_resp_valid = 2'b00; resp_ready = 1'b0;
    #1;
    check("D after pop req_ready", 64'(req_ready), 64'd1);

    // Reset with three requests outstanding discards every tag.
    do_reset();
    t_resp_valid = 2'b11; resp_ready = 1'b1;
    #1;
    check("R resp_valid", 64'(resp_valid), 64'd0);
    check("R req_ready", 64'(req_ready), 64'd1);
    check("R t_resp_ready", 64'(t_resp_ready), 64'b00);
    idle();
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_cfu = 2'd0;
      #1;
      if (req_ready) accepted++;
    end
    check("R refill accepted", 64'(accepted), 64'd4);
    do_reset();

    // Response stall: data held steady and nothing popped.
    @(negedge clk);
    req_valid = 1'b1; req_cfu = 2'd1;
    @(negedge clk);
    req_valid = 1'b0; t_resp_valid = 2'b10; t_resp_data[63:32] = 32'hC;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("E stall%0d resp_valid", c), 64'(resp_valid), 64'd1);
      check($sformatf("E stall%0d resp_data", c), 64'(resp_data), 64'hC);
      check($sformatf("E stall%0d t_resp_ready", c), 64'(t_resp_ready), 64'b00);
      @(negedge clk);
    end
    #1;
    check("E after stall resp_valid", 64'(resp_valid), 64'd1);

    // clk_en low: random traffic must produce no handshakes or state change.
    clk_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid    = 1'($urandom_range(0, 1));
      req_cfu      = 2'($urandom_range(0, 3));
      t_req_ready  = 2'($urandom_range(0, 3));
      t_resp_valid = 2'b11;
      resp_ready   = 1'b1;
      #1;
      check($sformatf("F%0d req_ready", c), 64'(req_ready), 64'd0);
      check($sformatf("F%0d t_req_valid", c), 64'(t_req_valid), 64'd0);
      check($sformatf("F%0d resp_valid", c), 64'(resp_valid), 64'd0);
      check($sformatf("F%0d t_resp_ready", c), 64'(t_resp_ready), 64'd0);
    end
    @(negedge clk);
    idle(); clk_en = 1'b1;
    t_resp_valid = 2'b10; t_resp_data[63:32] = 32'hC; resp_ready = 1'b1;
    #1;
    check("F held resp_valid", 64'(resp_valid), 64'd1);
    check("F held resp_data", 64'(resp_data), 64'hC);
    @(negedge clk);
    t_resp_valid = 2'b00;
    #1;
    check("F drained resp_valid", 64'(resp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
